// File: rtl/kernel_clk_monitor.sv
// kernel_clk_monitor
//   Watches one toggling bit of the kernel-clock ripple counter (typically
//   count[14]) from the 50 MHz board clock. It counts rising edges per
//   reference window, declares a stall after consecutive empty windows, and
//   drives the four active-low board LEDs with status patterns.
//
// Ports
//   i_clk         board clock, the only clock of this block
//   i_reset_n     asynchronous active-low reset
//   i_tick_in     counter bit from the kernel-clock domain (asynchronous)
//   o_rate_out    rising edges counted in the last completed window
//   o_rate_valid  one-cycle pulse when o_rate_out updates
//   o_stalled     kernel clock declared stopped
//   o_led_out     active-low LEDs: [3]=~stalled [2]=~activity
//                 [1]=~heartbeat [0]=~(state==RUN)
module kernel_clk_monitor #(
  parameter int REF_WINDOW    = 50_000_000,
  parameter int CNT_W         = 32,
  parameter int STALL_WINDOWS = 2,
  parameter int ACT_LEN       = 2_500_000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tick_in,
  output logic [CNT_W-1:0] o_rate_out,
  output logic             o_rate_valid,
  output logic             o_stalled,
  output logic [3:0]       o_led_out
);

  localparam int WIN_W = (REF_WINDOW > 1) ? $clog2(REF_WINDOW) : 1;
  localparam int ZW_W  = $clog2(STALL_WINDOWS + 1);
  localparam int ACT_W = (ACT_LEN > 0) ? $clog2(ACT_LEN + 1) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(REF_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ZW_W-1:0]  ZW_STALL = ZW_W'(STALL_WINDOWS);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_LEN);

  typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_STALL} state_t;

  // Two-flop synchronizer plus a history flop for rising-edge detection
  logic r_s1, r_s2, r_s3;

  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [ZW_W-1:0]  r_zero_win;
  logic [ACT_W-1:0] r_act_cnt;
  logic             r_heartbeat;
  state_t           r_state;

  logic [CNT_W-1:0] r_rate_out;
  logic             r_rate_valid;
  logic             r_stalled;
  logic [3:0]       r_led_out;

  logic             w_edge;
  logic             w_term;
  logic [CNT_W-1:0] w_edge_cnt_inc;
  logic             w_close_zero;
  logic [ZW_W-1:0]  w_zero_win_next;
  state_t           w_state_next;
  logic             w_heartbeat_next;
  logic [ACT_W-1:0] w_act_next;

  assign w_edge = r_s2 & ~r_s3;
  assign w_term = (r_win_cnt == WIN_LAST);

  // Saturating increment; on the terminal cycle this is also the closing
  // count, so an edge landing on term belongs to the window being closed.
  assign w_edge_cnt_inc = (w_edge && (r_edge_cnt != CNT_MAX)) ?
                          r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_close_zero   = (w_edge_cnt_inc == '0);

  always_comb begin
    w_zero_win_next  = r_zero_win;
    w_state_next     = r_state;
    w_heartbeat_next = r_heartbeat;
    if (w_term) begin
      w_heartbeat_next = ~r_heartbeat;
      if (w_close_zero) begin
        if (r_zero_win != ZW_STALL) begin
          w_zero_win_next = r_zero_win + ZW_W'(1);
        end
        if (w_zero_win_next == ZW_STALL) begin
          w_state_next = ST_STALL;
        end
      end else begin
        w_zero_win_next = '0;
        w_state_next    = ST_RUN;
      end
    end
  end

  // Reload (not accumulate) on every edge, otherwise count down to idle
  always_comb begin
    w_act_next = r_act_cnt;
    if (w_edge) begin
      w_act_next = ACT_LOAD;
    end else if (r_act_cnt != '0) begin
      w_act_next = r_act_cnt - ACT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_zero_win   <= '0;
      r_act_cnt    <= '0;
      r_heartbeat  <= 1'b0;
      r_state      <= ST_WARMUP;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
      r_stalled    <= 1'b0;
      r_led_out    <= 4'b1111;
    end else begin
      r_s1 <= i_tick_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      r_win_cnt  <= w_term ? '0 : r_win_cnt + WIN_W'(1);
      r_edge_cnt <= w_term ? '0 : w_edge_cnt_inc;
      if (w_term) begin
        r_rate_out <= w_edge_cnt_inc;
      end
      r_rate_valid <= w_term;

      r_zero_win  <= w_zero_win_next;
      r_state     <= w_state_next;
      r_heartbeat <= w_heartbeat_next;
      r_act_cnt   <= w_act_next;

      // LEDs are built from next-state values so they change on the same
      // edge as the state they display.
      r_stalled <= (w_state_next == ST_STALL);
      r_led_out <= {~(w_state_next == ST_STALL),
                    ~(w_act_next != '0),
                    ~w_heartbeat_next,
                    ~(w_state_next == ST_RUN)};
    end
  end

  assign o_rate_out   = r_rate_out;
  assign o_rate_valid = r_rate_valid;
  assign o_stalled    = r_stalled;
  assign o_led_out    = r_led_out;

endmodule

// File: tb/tb_kernel_clk_monitor.sv
// Testbench for kernel_clk_monitor: two instances (CNT_W=8 and CNT_W=4)
// share one stimulus stream. Window results are predicted from the driven
// tick pattern, pushed to a scoreboard and popped when rate_valid fires.
module tb_kernel_clk_monitor;

  localparam int REF = 100;
  localparam int ACT = 8;

  localparam int M_SQ10 = 0;  // period 10: high 5, low 5
  localparam int M_TERM = 1;  // single rise whose edge lands on term
  localparam int M_IDLE = 2;  // tick held low
  localparam int M_SQ4  = 3;  // period 4: high 2, low 2

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] rate8;
  logic [3:0] rate4;
  logic       rv8, rv4, st8, st4;
  logic [3:0] led8, led4;

  always #5 clk = ~clk;

  kernel_clk_monitor #(
    .REF_WINDOW(REF), .CNT_W(8), .STALL_WINDOWS(2), .ACT_LEN(ACT)
  ) u_dut8 (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick_in(tick),
    .o_rate_out(rate8), .o_rate_valid(rv8), .o_stalled(st8), .o_led_out(led8)
  );

  kernel_clk_monitor #(
    .REF_WINDOW(REF), .CNT_W(4), .STALL_WINDOWS(2), .ACT_LEN(ACT)
  ) u_dut4 (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick_in(tick),
    .o_rate_out(rate4), .o_rate_valid(rv4), .o_stalled(st4), .o_led_out(led4)
  );

  typedef struct {
    int       cyc;
    int       rate8;
    int       rate4;
    bit       stalled;
    bit [2:0] led_static;  // expected {led[3], led[1], led[0]}
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad = 0;

  // Reference model state (counted in clk posedges since reset release)
  int       cyc;
  bit       prev_lvl;
  int       e_last, e_prev;
  int       win_edges[0:15];
  int       zw;
  int       st;  // 0 warmup, 1 run, 2 stall
  bit       hb;
  int       cur_rate8, cur_rate4;
  bit       cur_stalled;
  bit [2:0] cur_static;

  int modes_a[12] = '{M_IDLE, M_IDLE, M_SQ10, M_SQ10, M_SQ10, M_TERM,
                      M_IDLE, M_IDLE, M_SQ10, M_SQ4, M_SQ4, M_SQ10};
  int modes_b[2]  = '{M_SQ10, M_SQ10};

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  function automatic bit lvl_of(input int mode, input int p);
    case (mode)
      M_SQ10:  return (p % 10) < 5;
      M_TERM:  return (p % REF) >= REF - 3;
      M_SQ4:   return (p % 4) < 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic reset_model();
    cyc      = 0;
    prev_lvl = 1'b0;
    e_last   = -100;
    e_prev   = -100;
    for (int w = 0; w < 16; w++) win_edges[w] = 0;
    zw  = 0;
    st  = 0;
    hb  = 1'b0;
    sb_q.delete();
    cur_rate8   = 0;
    cur_rate4   = 0;
    cur_stalled = 1'b0;
    cur_static  = 3'b111;
  endtask

  task automatic check_reset(input string tag);
    check_value({tag, "_rate8"}, rate8, 0);
    check_value({tag, "_rate4"}, rate4, 0);
    check_value({tag, "_rv8"}, rv8, 0);
    check_value({tag, "_rv4"}, rv4, 0);
    check_value({tag, "_st8"}, st8, 0);
    check_value({tag, "_st4"}, st4, 0);
    check_value({tag, "_led8"}, led8, 4'hF);
    check_value({tag, "_led4"}, led4, 4'hF);
  endtask

  // Close window w: all edges it can contain are already known.
  task automatic close_window(input int w);
    exp_t e;
    int   cnt;
    cnt = win_edges[w];
    if (cnt == 0) begin
      if (zw < 2) zw++;
      if (zw == 2) st = 2;
    end else begin
      zw = 0;
      st = 1;
    end
    hb = ~hb;
    e.cyc        = w * REF + REF - 1;
    e.rate8      = sat(cnt, 255);
    e.rate4      = sat(cnt, 15);
    e.stalled    = (st == 2);
    e.led_static = {st != 2, ~hb, st != 1};
    sb_q.push_back(e);
  endtask

  task automatic monitor(input int p);
    exp_t     e;
    int       latest;
    bit       active;
    bit [3:0] exp_led;
    latest = (e_last <= p) ? e_last : e_prev;
    active = (latest >= 0) && ((p - latest) < ACT);
    if (sb_q.size() > 0 && sb_q[0].cyc == p) begin
      e = sb_q.pop_front();
      cur_rate8   = e.rate8;
      cur_rate4   = e.rate4;
      cur_stalled = e.stalled;
      cur_static  = e.led_static;
      check_value("rv8_term", rv8, 1);
      check_value("rv4_term", rv4, 1);
      $display("txn window_end cyc=%0d rate8=%0d rate4=%0d stalled=%0d led8=%b",
               p, rate8, rate4, st8, led8);
    end else begin
      check_value("rv8_idle", rv8, 0);
      check_value("rv4_idle", rv4, 0);
    end
    exp_led = {cur_static[2], ~active, cur_static[1], cur_static[0]};
    check_value("rate8", rate8, cur_rate8);
    check_value("rate4", rate4, cur_rate4);
    check_value("stalled8", st8, cur_stalled);
    check_value("stalled4", st4, cur_stalled);
    check_value("led8", led8, exp_led);
    check_value("led4", led4, exp_led);
  endtask

  // Called just after a negedge: drive the level sampled at posedge cyc.
  task automatic step(input bit lvl);
    tick = lvl;
    if (lvl && !prev_lvl) begin
      // Sampled at posedge cyc, counted at posedge cyc+2
      e_prev = e_last;
      e_last = cyc + 2;
      win_edges[(cyc + 2) / REF]++;
    end
    prev_lvl = lvl;
    if (cyc % REF == REF - 3) close_window(cyc / REF);
    @(posedge clk);
    @(negedge clk);
    monitor(cyc);
    cyc++;
  endtask

  initial begin
    // Reset held with tick toggling
    reset_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tick = i[1];
      if (i % 4 == 3) check_reset("hold_rst");
    end
    @(negedge clk);
    tick = 1'b0;
    reset_n = 1'b1;
    reset_model();

    // Phase A: warmup stall, steady run, terminal edge, stall/recovery,
    // saturation, then a partial window interrupted at win_cnt=50.
    while (cyc < 11 * REF + 50) step(lvl_of(modes_a[cyc / REF], cyc));

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1 check_reset("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick = i[0];
    end
    tick = 1'b0;
    reset_n = 1'b1;
    reset_model();

    // Phase B: fresh full window that must not include pre-reset edges
    while (cyc < 2 * REF) step(lvl_of(modes_b[cyc / REF], cyc));

    check_value("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
